// File: rtl/musb_muldiv_pkg.sv
// Shared types for the multiply/divide unit: op codes, FSM states, operand context.
package musb_muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } muldiv_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL1 = 3'd1,
        ST_MUL2 = 3'd2,
        ST_DIV  = 3'd3,
        ST_FIX  = 3'd4
    } muldiv_state_e;

    // Operands captured when a MULT/DIV is accepted; used until the result is written.
    typedef struct packed {
        logic            is_signed;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } muldiv_ctx_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is correct unsigned.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? (XLEN'(0) - x) : x;
    endfunction

endpackage

// File: rtl/musb_muldiv_if.sv
// EX-stage <-> mul/div unit signal bundle.
//   master: drives op, operands, flush, pipe_stall; sees stall, result, hi, lo.
//   slave : the mul/div unit.
interface musb_muldiv_if;
    import musb_muldiv_pkg::*;

    muldiv_op_e      ex_muldiv_op;
    logic [XLEN-1:0] ex_data_rs;
    logic [XLEN-1:0] ex_data_rt;
    logic            ex_flush;
    logic            pipe_stall;
    logic            muldiv_stall;
    logic [XLEN-1:0] muldiv_result;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output ex_muldiv_op, ex_data_rs, ex_data_rt, ex_flush, pipe_stall,
        input  muldiv_stall, muldiv_result, hi, lo
    );

    modport slave (
        input  ex_muldiv_op, ex_data_rs, ex_data_rt, ex_flush, pipe_stall,
        output muldiv_stall, muldiv_result, hi, lo
    );
endinterface

// File: rtl/musb_div_iter.sv
// 32-step restoring divider on unsigned magnitudes, one quotient bit per cycle.
//   start     : load operands (counter = 31)
//   done_c    : high during the final step (counter = 0)
//   quotient  : quotient shift register (valid the cycle after done_c)
//   remainder : partial remainder (valid the cycle after done_c)
module musb_div_iter
    import musb_muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done_c,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic             running_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dsr_q;

    logic [XLEN:0]    shifted_c;
    logic [XLEN:0]    diff_c;
    logic             take_c;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        shifted_c = {rem_q, quo_q[XLEN-1]};
        diff_c    = shifted_c - {1'b0, dsr_q};
        take_c    = ~diff_c[XLEN];
        done_c    = running_q && (cnt_q == CNT_W'(0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
        end else if (start) begin
            running_q <= 1'b1;
            cnt_q     <= CNT_W'(XLEN - 1);
            rem_q     <= '0;
            quo_q     <= dividend;
            dsr_q     <= divisor;
        end else if (running_q) begin
            rem_q <= take_c ? diff_c[XLEN-1:0] : shifted_c[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], take_c};
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(0)) running_q <= 1'b0;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/musb_muldiv.sv
// EX-stage multiply/divide unit owning HI/LO. MULT/DIV run in the background;
// later HI/LO ops stall (combinationally) until the unit is idle.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of musb_muldiv_if (op/operands in, stall/result/hi/lo out)
module musb_muldiv
    import musb_muldiv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    musb_muldiv_if.slave       bus
);

    muldiv_state_e   state_q, state_d;
    muldiv_ctx_t     ctx_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0] hi_q, lo_q;

    logic            valid_c, accept_c, div_start_c, div_done_c;
    logic            stall_c;
    logic [XLEN-1:0] result_c;
    logic [XLEN-1:0] div_a_c, div_b_c, quo_c, rem_c;
    logic [XLEN-1:0] fix_hi_c, fix_lo_c;
    logic [2*XLEN-1:0] ext_a_c, ext_b_c;

    musb_div_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_c),
        .dividend  (div_a_c),
        .divisor   (div_b_c),
        .done_c    (div_done_c),
        .quotient  (quo_c),
        .remainder (rem_c)
    );

    // Next state, acceptance, stall and MFHI/MFLO read-out.
    always_comb begin
        state_d     = state_q;
        accept_c    = 1'b0;
        div_start_c = 1'b0;
        valid_c     = (bus.ex_muldiv_op != OP_NONE) && !bus.ex_flush;
        stall_c     = (state_q != ST_IDLE) && valid_c;
        result_c    = '0;
        if (bus.ex_muldiv_op == OP_MFHI) result_c = hi_q;
        if (bus.ex_muldiv_op == OP_MFLO) result_c = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_c && !bus.pipe_stall) begin
                    accept_c = 1'b1;
                    case (bus.ex_muldiv_op)
                        OP_MULT, OP_MULTU: state_d = ST_MUL1;
                        OP_DIV, OP_DIVU: begin
                            state_d     = ST_DIV;
                            div_start_c = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL1: state_d = ST_MUL2;
            ST_MUL2: state_d = ST_IDLE;
            ST_DIV:  if (div_done_c) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Divider operands: magnitudes for DIV, raw for DIVU.
    always_comb begin
        div_a_c = bus.ex_data_rs;
        div_b_c = bus.ex_data_rt;
        if (bus.ex_muldiv_op == OP_DIV) begin
            div_a_c = abs_val(bus.ex_data_rs);
            div_b_c = abs_val(bus.ex_data_rt);
        end
    end

    // Sign/zero-divisor correction of the raw divider result.
    always_comb begin
        fix_lo_c = quo_c;
        fix_hi_c = rem_c;
        if (ctx_q.b == '0) begin
            fix_lo_c = '1;
            fix_hi_c = ctx_q.a;
        end else if (ctx_q.is_signed) begin
            if (ctx_q.a[XLEN-1] ^ ctx_q.b[XLEN-1]) fix_lo_c = XLEN'(0) - quo_c;
            if (ctx_q.a[XLEN-1])                   fix_hi_c = XLEN'(0) - rem_c;
        end
    end

    // Sign- or zero-extend operands so a 64-bit product is exact for both forms.
    always_comb begin
        ext_a_c = {{XLEN{ctx_q.is_signed & ctx_q.a[XLEN-1]}}, ctx_q.a};
        ext_b_c = {{XLEN{ctx_q.is_signed & ctx_q.b[XLEN-1]}}, ctx_q.b};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Operand capture, product register and HI/LO update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctx_q  <= '0;
            prod_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            if (accept_c) begin
                case (bus.ex_muldiv_op)
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        ctx_q.is_signed <= (bus.ex_muldiv_op == OP_MULT) ||
                                           (bus.ex_muldiv_op == OP_DIV);
                        ctx_q.a         <= bus.ex_data_rs;
                        ctx_q.b         <= bus.ex_data_rt;
                    end
                    OP_MTHI: hi_q <= bus.ex_data_rs;
                    OP_MTLO: lo_q <= bus.ex_data_rs;
                    default: ;
                endcase
            end
            if (state_q == ST_MUL1) prod_q <= ext_a_c * ext_b_c;
            if (state_q == ST_MUL2) {hi_q, lo_q} <= prod_q;
            if (state_q == ST_FIX) begin
                hi_q <= fix_hi_c;
                lo_q <= fix_lo_c;
            end
        end
    end

    assign bus.muldiv_stall  = stall_c;
    assign bus.muldiv_result = result_c;
    assign bus.hi            = hi_q;
    assign bus.lo            = lo_q;

endmodule

// File: tb/tb_musb_muldiv.sv
// Directed self-checking bench for musb_muldiv.
module tb_musb_muldiv;
    import musb_muldiv_pkg::*;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    musb_muldiv_if bus ();

    musb_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic drive(input muldiv_op_e op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic fl, input logic ps);
        bus.ex_muldiv_op = op;
        bus.ex_data_rs   = rs;
        bus.ex_data_rt   = rt;
        bus.ex_flush     = fl;
        bus.pipe_stall   = ps;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) next_cycle();
        #2;
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=%h", bus.hi, 32'h0); end
        checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=%h", bus.lo, 32'h0); end
        checks++; if (bus.muldiv_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.muldiv_stall); end
        checks++; if (bus.muldiv_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=%h", bus.muldiv_result, 32'h0); end
        rst = 1'b0;
        next_cycle();
    endtask

    // MULT/MULTU then MFLO right behind it: expect exactly 2 stall cycles.
    task automatic test_mult(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        int n;
        drive(op, a, b, 1'b0, 1'b0);
        #2;
        checks++; if (bus.muldiv_stall !== 1'b0) begin errors++; $display("FAIL %s_issue_stall got=%b exp=0", name, bus.muldiv_stall); end
        next_cycle();
        drive(OP_MFLO, 32'h0, 32'h0, 1'b0, 1'b0);
        n = 0;
        #2;
        while (bus.muldiv_stall === 1'b1 && n < 50) begin
            n++;
            next_cycle();
            #2;
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL %s_stall_cycles got=%0d exp=2", name, n); end
        checks++; if (bus.muldiv_result !== exp_lo) begin errors++; $display("FAIL %s_mflo got=%h exp=%h", name, bus.muldiv_result, exp_lo); end
        checks++; if (bus.hi !== exp_hi) begin errors++; $display("FAIL %s_hi got=%h exp=%h", name, bus.hi, exp_hi); end
        drive(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
        next_cycle();
    endtask

    // Preload HI, run a divide, confirm HI is still old in FIX and updated in the first idle cycle.
    task automatic test_div(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        int          n;
        logic [31:0] hi_fix;
        hi_fix = 32'h0;
        drive(OP_MTHI, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        next_cycle();
        drive(op, a, b, 1'b0, 1'b0);
        #2;
        checks++; if (bus.muldiv_stall !== 1'b0) begin errors++; $display("FAIL %s_issue_stall got=%b exp=0", name, bus.muldiv_stall); end
        next_cycle();
        drive(OP_MFHI, 32'h0, 32'h0, 1'b0, 1'b0);
        n = 0;
        #2;
        while (bus.muldiv_stall === 1'b1 && n < 100) begin
            if (n == 32) hi_fix = bus.hi;
            n++;
            next_cycle();
            #2;
        end
        checks++; if (n !== 33) begin errors++; $display("FAIL %s_stall_cycles got=%0d exp=33", name, n); end
        checks++; if (hi_fix !== 32'hDEADBEEF) begin errors++; $display("FAIL %s_hi_in_fix got=%h exp=%h", name, hi_fix, 32'hDEADBEEF); end
        checks++; if (bus.muldiv_result !== exp_hi) begin errors++; $display("FAIL %s_mfhi got=%h exp=%h", name, bus.muldiv_result, exp_hi); end
        checks++; if (bus.lo !== exp_lo) begin errors++; $display("FAIL %s_lo got=%h exp=%h", name, bus.lo, exp_lo); end
        drive(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
        next_cycle();
    endtask

    task automatic test_mt_pipe_stall();
        drive(OP_MTHI, 32'h11111111, 32'h0, 1'b0, 1'b0);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            drive(OP_MTHI, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1);
            #2;
            checks++; if (bus.muldiv_stall !== 1'b0) begin errors++; $display("FAIL pstall_stall%0d got=%b exp=0", i, bus.muldiv_stall); end
            next_cycle();
            checks++; if (bus.hi !== 32'h11111111) begin errors++; $display("FAIL pstall_hi%0d got=%h exp=%h", i, bus.hi, 32'h11111111); end
        end
        drive(OP_MTHI, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
        next_cycle();
        checks++; if (bus.hi !== 32'hA5A5A5A5) begin errors++; $display("FAIL pstall_release_hi got=%h exp=%h", bus.hi, 32'hA5A5A5A5); end
        drive(OP_MTHI, 32'h5A5A5A5A, 32'h0, 1'b1, 1'b0);
        #2;
        checks++; if (bus.muldiv_stall !== 1'b0) begin errors++; $display("FAIL flush_mthi_stall got=%b exp=0", bus.muldiv_stall); end
        next_cycle();
        checks++; if (bus.hi !== 32'hA5A5A5A5) begin errors++; $display("FAIL flush_mthi_hi got=%h exp=%h", bus.hi, 32'hA5A5A5A5); end
        drive(OP_MTLO, 32'h0F0F0F0F, 32'h0, 1'b0, 1'b0);
        next_cycle();
        drive(OP_MFLO, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        checks++; if (bus.muldiv_result !== 32'h0F0F0F0F) begin errors++; $display("FAIL mtlo_mflo got=%h exp=%h", bus.muldiv_result, 32'h0F0F0F0F); end
        drive(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
        next_cycle();
    endtask

    task automatic test_reset_mid_div();
        drive(OP_MTHI, 32'h12345678, 32'h0, 1'b0, 1'b0);
        next_cycle();
        drive(OP_MTLO, 32'h87654321, 32'h0, 1'b0, 1'b0);
        next_cycle();
        drive(OP_DIV, 32'd100, 32'd3, 1'b0, 1'b0);
        next_cycle();
        drive(OP_MFHI, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (9) next_cycle();
        #2;
        checks++; if (bus.muldiv_stall !== 1'b1) begin errors++; $display("FAIL rstdiv_busy_stall got=%b exp=1", bus.muldiv_stall); end
        rst = 1'b1;
        #1;
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL rstdiv_hi got=%h exp=%h", bus.hi, 32'h0); end
        checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL rstdiv_lo got=%h exp=%h", bus.lo, 32'h0); end
        checks++; if (bus.muldiv_stall !== 1'b0) begin errors++; $display("FAIL rstdiv_stall got=%b exp=0", bus.muldiv_stall); end
        next_cycle();
        rst = 1'b0;
        drive(OP_MTLO, 32'h00000077, 32'h0, 1'b0, 1'b0);
        #2;
        checks++; if (bus.muldiv_stall !== 1'b0) begin errors++; $display("FAIL rstdiv_idle_stall got=%b exp=0", bus.muldiv_stall); end
        next_cycle();
        checks++; if (bus.lo !== 32'h00000077) begin errors++; $display("FAIL rstdiv_mtlo got=%h exp=%h", bus.lo, 32'h77); end
        drive(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int n;
        drive(OP_MULT, 32'd3, 32'd5, 1'b0, 1'b0);
        next_cycle();
        drive(OP_MULT, 32'd7, 32'd9, 1'b0, 1'b0);
        n = 0;
        #2;
        while (bus.muldiv_stall === 1'b1 && n < 50) begin
            n++;
            next_cycle();
            #2;
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_stall_cycles got=%0d exp=2", n); end
        checks++; if (bus.lo !== 32'd15) begin errors++; $display("FAIL b2b_first_lo got=%h exp=%h", bus.lo, 32'd15); end
        next_cycle();
        drive(OP_MFLO, 32'h0, 32'h0, 1'b0, 1'b0);
        n = 0;
        #2;
        while (bus.muldiv_stall === 1'b1 && n < 50) begin
            n++;
            next_cycle();
            #2;
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_mflo_stall got=%0d exp=2", n); end
        checks++; if (bus.muldiv_result !== 32'd63) begin errors++; $display("FAIL b2b_second_lo got=%h exp=%h", bus.muldiv_result, 32'd63); end
        drive(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
        next_cycle();
    endtask

    // DIVU 100/7 followed by a MULT 6*7 that waits out the divide; a flushed op at E+5 must not stall.
    task automatic test_div_flush_mult();
        int n;
        int early;
        drive(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
        next_cycle();
        early = 0;
        for (int i = 0; i < 4; i++) begin
            drive(OP_MULT, 32'd6, 32'd7, 1'b0, 1'b0);
            #2;
            if (bus.muldiv_stall === 1'b1) early++;
            next_cycle();
        end
        checks++; if (early !== 4) begin errors++; $display("FAIL dfm_early_stalls got=%0d exp=4", early); end
        drive(OP_MFHI, 32'h0, 32'h0, 1'b1, 1'b0);
        #2;
        checks++; if (bus.muldiv_stall !== 1'b0) begin errors++; $display("FAIL dfm_flush_stall got=%b exp=0", bus.muldiv_stall); end
        next_cycle();
        drive(OP_MULT, 32'd6, 32'd7, 1'b0, 1'b0);
        n = 0;
        #2;
        while (bus.muldiv_stall === 1'b1 && n < 100) begin
            n++;
            next_cycle();
            #2;
        end
        checks++; if (n !== 28) begin errors++; $display("FAIL dfm_late_stalls got=%0d exp=28", n); end
        checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL dfm_div_lo got=%h exp=%h", bus.lo, 32'd14); end
        checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL dfm_div_hi got=%h exp=%h", bus.hi, 32'd2); end
        next_cycle();
        drive(OP_MFLO, 32'h0, 32'h0, 1'b0, 1'b0);
        n = 0;
        #2;
        while (bus.muldiv_stall === 1'b1 && n < 50) begin
            n++;
            next_cycle();
            #2;
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL dfm_mflo_stall got=%0d exp=2", n); end
        checks++; if (bus.muldiv_result !== 32'd42) begin errors++; $display("FAIL dfm_mult_lo got=%h exp=%h", bus.muldiv_result, 32'd42); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL dfm_mult_hi got=%h exp=%h", bus.hi, 32'h0); end
        drive(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_mult(OP_MULT,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult");
        test_mult(OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, "multu");
        test_div(OP_DIV,  32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2");
        test_div(OP_DIVU, 32'd7,        32'd2,       32'h00000001, 32'h00000003, "divu_7_2");
        test_div(OP_DIVU, 32'h1234,     32'h0,       32'h00001234, 32'hFFFFFFFF, "divu_by0");
        test_div(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf");
        test_div(OP_DIV,  32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, "div_100_neg7");
        test_mt_pipe_stall();
        test_reset_mid_div();
        test_back_to_back();
        test_div_flush_mult();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
